// File: rtl/ucsbece154b_sdram_ctrl.sv
// ucsbece154b_sdram_ctrl
// Behavioural SDRAM/PSRAM responder that serves instruction-cache block refills.
// An accepted read request waits T0_DELAY cycles. The controller then streams
// BLOCK_SIZE words, one per cycle, with the critical word first when that is
// enabled. A separate write port preloads the word-addressed backing memory.
//
// Ports:
//   clk                 clock; all state changes on the rising edge
//   reset_i             synchronous active-high reset (memory is not cleared)
//   sdramReadRequest_i  read request; sampled only while idle
//   sdramReadAddress_i  byte address of the missing word
//   sdramDataReady_o    high while a burst word is valid
//   sdramDataOut_o      burst data word (holds its last value after the burst)
//   busy_o              high while waiting for or streaming a burst
//   writeEnable_i       preload write strobe
//   writeAddress_i      preload byte address
//   writeData_i         preload data
module ucsbece154b_sdram_ctrl #(
    parameter int BLOCK_SIZE     = 4,
    parameter int T0_DELAY       = 10,
    parameter int MEM_WORDS      = 4096,
    parameter int CRITICAL_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        sdramReadRequest_i,
    input  logic [31:0] sdramReadAddress_i,
    output logic        sdramDataReady_o,
    output logic [31:0] sdramDataOut_o,
    output logic        busy_o,
    input  logic        writeEnable_i,
    input  logic [31:0] writeAddress_i,
    input  logic [31:0] writeData_i
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int OW = $clog2(BLOCK_SIZE);
    localparam int BW = OW + 1;
    localparam int CW = (T0_DELAY > 1) ? $clog2(T0_DELAY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t           state_r, state_nx_s;
    logic [CW-1:0]    lat_cnt_r, lat_cnt_nx_s;
    logic [BW-1:0]    beat_r, beat_nx_s;
    logic [AW-OW-1:0] blk_r;
    logic [OW-1:0]    off_r;
    logic             accept_s;
    logic             present_s;
    logic [OW-1:0]    pos_s;
    logic [AW-1:0]    rd_idx_s;
    logic             ready_r;
    logic [31:0]      data_r;
    logic             busy_r;
    logic [31:0]      mem_r [MEM_WORDS];

    // Offset within the block that beat k presents. In critical-first mode,
    // beat 0 is the requested word. Later beats count upward and skip that word.
    function automatic logic [OW-1:0] beat_offset(input logic [OW-1:0] k,
                                                  input logic [OW-1:0] crit);
        logic [OW-1:0] km1;
        km1 = k - OW'(1);
        if (CRITICAL_FIRST == 0) begin
            return k;
        end else if (k == OW'(0)) begin
            return crit;
        end else if (km1 < crit) begin
            return km1;
        end else begin
            return k;
        end
    endfunction

    assign pos_s    = beat_offset(beat_r[OW-1:0], off_r);
    assign rd_idx_s = {blk_r, pos_s};

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = sdramReadRequest_i ? WAIT : IDLE;
            WAIT:    state_nx_s = (lat_cnt_r == CW'(0)) ? BURST : WAIT;
            BURST:   state_nx_s = (beat_r == BW'(BLOCK_SIZE)) ? IDLE : BURST;
            default: state_nx_s = IDLE;
        endcase
    end

    // Counter updates, request acceptance and word-present strobe per state
    always_comb begin
        lat_cnt_nx_s = lat_cnt_r;
        beat_nx_s    = beat_r;
        accept_s     = 1'b0;
        present_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (sdramReadRequest_i) begin
                    accept_s     = 1'b1;
                    lat_cnt_nx_s = CW'(T0_DELAY - 1);
                    beat_nx_s    = BW'(0);
                end else begin
                    accept_s     = 1'b0;
                end
            end
            WAIT: begin
                // The edge that leaves WAIT also presents the first word.
                if (lat_cnt_r == CW'(0)) begin
                    present_s = 1'b1;
                    beat_nx_s = beat_r + BW'(1);
                end else begin
                    lat_cnt_nx_s = lat_cnt_r - CW'(1);
                end
            end
            BURST: begin
                if (beat_r == BW'(BLOCK_SIZE)) begin
                    beat_nx_s = BW'(0);
                end else begin
                    present_s = 1'b1;
                    beat_nx_s = beat_r + BW'(1);
                end
            end
            default: begin
                lat_cnt_nx_s = CW'(0);
                beat_nx_s    = BW'(0);
            end
        endcase
    end

    // State, counters, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_r   <= IDLE;
            lat_cnt_r <= CW'(0);
            beat_r    <= BW'(0);
            blk_r     <= '0;
            off_r     <= '0;
            ready_r   <= 1'b0;
            data_r    <= 32'd0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            lat_cnt_r <= lat_cnt_nx_s;
            beat_r    <= beat_nx_s;
            if (accept_s) begin
                blk_r <= sdramReadAddress_i[AW+1:OW+2];
                off_r <= sdramReadAddress_i[OW+1:2];
            end
            ready_r <= present_s;
            if (present_s) begin
                data_r <= mem_r[rd_idx_s];
            end
            busy_r <= (state_nx_s != IDLE);
        end
    end

    // Preload port. A write and a burst read to the same word on one edge
    // return the old contents. Reset does not clear the memory.
    always_ff @(posedge clk) begin
        if (writeEnable_i) begin
            mem_r[writeAddress_i[AW+1:2]] <= writeData_i;
        end
    end

    assign sdramDataReady_o = ready_r;
    assign sdramDataOut_o   = data_r;
    assign busy_o           = busy_r;

    // Address bits outside the word index are intentionally ignored.
    logic unused_s;
    assign unused_s = ^{sdramReadAddress_i[31:AW+2], sdramReadAddress_i[1:0],
                        writeAddress_i[31:AW+2], writeAddress_i[1:0]};

endmodule
